// File: rtl/aes_key_pkg.sv
// rtl/aes_key_pkg.sv - shared types, key-length decode and GF helpers for the AES key expander
package aes_key_pkg;

  localparam logic [1:0] KL_128 = 2'b00;
  localparam logic [1:0] KL_192 = 2'b01;
  localparam logic [1:0] KL_256 = 2'b10;
  localparam logic [1:0] KL_BAD = 2'b11;

  localparam int RK_BITS = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_OUTPUT
  } state_t;

  // Words in the cipher key (Nk)
  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return 4'd4;
      KL_192:  return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  // Number of rounds (Nr)
  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return 4'd10;
      KL_192:  return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  // Total schedule words W = 4(Nr+1)
  function automatic logic [5:0] w_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return 6'd44;
      KL_192:  return 6'd52;
      default: return 6'd60;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - AES forward S-box, one byte in, one byte out
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Entry n sits at bits [2047-8n -: 8]; row 0 of the table is the most significant slice
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = SBOX_TAB[11'd2047 - {din, 3'b000} -: 8];

endmodule

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - 32-bit SubWord from four byte S-boxes
module aes_sub_word (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    aes_sbox u_sbox (
      .din  (din[8*b +: 8]),
      .dout (dout[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - sequential AES-128/192/256 key schedule with forward/reverse round-key stream
module aes_key_expander
  import aes_key_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              key_len,
  input  logic                    reverse,
  input  logic [MAX_KEY_BITS-1:0] key_in,
  output logic                    busy,
  output logic                    err,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic [RK_BITS-1:0]      rk_data,
  output logic [3:0]              rk_index,
  output logic                    rk_last
);

  localparam int DEPTH     = (MAX_KEY_BITS == 128) ? 44 : (MAX_KEY_BITS == 192) ? 52 : 60;
  localparam int KEY_WORDS = MAX_KEY_BITS / 32;

  state_t                  state_q, state_d;
  logic [31:0]             wbuf [DEPTH];
  logic [MAX_KEY_BITS-1:0] key_q;
  logic [1:0]              len_q;
  logic                    rev_q;
  logic [5:0]              i_q;
  logic [2:0]              mod_q;
  logic [7:0]              rcon_q;
  logic [3:0]              k_q;
  logic                    err_q;

  logic [3:0]  nk, nr;
  logic [5:0]  wlast, rk_base;
  logic        start_ok, hs;
  logic [31:0] prev_w, back_w, sub_in, sub_out, temp_w, new_w;

  assign nk      = nk_of(len_q);
  assign nr      = nr_of(len_q);
  assign wlast   = w_of(len_q) - 6'd1;
  assign rk_base = {k_q, 2'b00};
  assign err     = err_q;
  assign hs      = rk_valid & rk_ready;

  // A key wider than the buffer was sized for is rejected like an illegal encoding
  assign start_ok = start && (key_len != KL_BAD) && (32 * int'(nk_of(key_len)) <= MAX_KEY_BITS);

  // One schedule word per cycle; the single SubWord serves both the RotWord and AES-256 mid-key steps
  assign prev_w = wbuf[i_q - 6'd1];
  assign back_w = wbuf[i_q - {2'b00, nk}];
  assign sub_in = (mod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  aes_sub_word u_sub_word (
    .din  (sub_in),
    .dout (sub_out)
  );

  assign temp_w = (mod_q == 3'd0)                  ? (sub_out ^ {rcon_q, 24'h0}) :
                  ((nk == 4'd8) && (mod_q == 3'd4)) ? sub_out : prev_w;
  assign new_w  = back_w ^ temp_w;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and round-key outputs; outputs are zero outside OUTPUT
  always_comb begin
    state_d  = state_q;
    busy     = (state_q != ST_IDLE);
    rk_valid = 1'b0;
    rk_data  = '0;
    rk_index = '0;
    rk_last  = 1'b0;
    if (state_q == ST_OUTPUT) begin
      rk_valid = 1'b1;
      rk_data  = {wbuf[rk_base], wbuf[rk_base + 6'd1], wbuf[rk_base + 6'd2], wbuf[rk_base + 6'd3]};
      rk_index = k_q;
      rk_last  = rev_q ? (k_q == 4'd0) : (k_q == nr);
    end
    case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_EXPAND;
      ST_EXPAND: if (i_q == wlast) state_d = ST_OUTPUT;
      ST_OUTPUT: if (hs && rk_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Control registers: job settings, word counter, i mod Nk, Rcon and round-key pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      key_q  <= '0;
      len_q  <= KL_128;
      rev_q  <= 1'b0;
      i_q    <= '0;
      mod_q  <= '0;
      rcon_q <= 8'h01;
      k_q    <= '0;
    end else begin
      err_q <= (state_q == ST_IDLE) && start && !start_ok;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            key_q <= key_in;
            len_q <= key_len;
            rev_q <= reverse;
          end
        end
        ST_LOAD: begin
          i_q    <= {2'b00, nk};
          mod_q  <= '0;
          rcon_q <= 8'h01;
        end
        ST_EXPAND: begin
          i_q   <= i_q + 6'd1;
          mod_q <= ({1'b0, mod_q} == nk - 4'd1) ? 3'd0 : mod_q + 3'd1;
          if (mod_q == 3'd0) rcon_q <= xtime(rcon_q);
          if (i_q == wlast) k_q <= rev_q ? nr : 4'd0;
        end
        ST_OUTPUT: begin
          if (hs && !rk_last) k_q <= rev_q ? k_q - 4'd1 : k_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Word buffer: key words on LOAD, one expanded word per EXPAND cycle; contents need no reset
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD) begin
      for (int j = 0; j < KEY_WORDS; j++) begin
        if (j < int'(nk)) wbuf[j] <= key_q[MAX_KEY_BITS-1-32*j -: 32];
      end
    end else if (state_q == ST_EXPAND) begin
      wbuf[i_q] <= new_w;
    end
  end

endmodule
